mse_serial_slave: RTL and testbench

Serial-to-parallel front end for one MSE lane. Deserialises MSE frames (SCLK/SDI/SLE) into single-cycle register-bus strobes (address, data, wr, rd) consumed by the port I/O register block. Shifts read data back on SDO and reports readiness on SRDY. All MSE pins are oversampled in the `clk` domain; there is no logic clocked by SCLK.

---
 rtl/mse_serial_slave_if.sv | 25 ++
 rtl/mse_serial_slave.sv | 169 ++++++++++++++++
 tb/tb_mse_serial_slave.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/mse_serial_slave_if.sv
// MSE lane pins plus the register-bus strobes exchanged with the port I/O register block.
// The slave modport is the deserialiser's view; the master modport is the MSE master and register-block view.
interface mse_serial_slave_if;
  logic        mse_sclk;
  logic        mse_sdi;
  logic        mse_sle;
  logic        mse_sdo;
  logic        mse_srdy;
  logic [7:0]  address;
  logic [15:0] data;
  logic [15:0] rdata;
  logic        wr;
  logic        rd;
  logic        frame_err;

  modport slave (
    input  mse_sclk, mse_sdi, mse_sle, rdata,
    output mse_sdo, mse_srdy, address, data, wr, rd, frame_err
  );

  modport master (
    output mse_sclk, mse_sdi, mse_sle, rdata,
    input  mse_sdo, mse_srdy, address, data, wr, rd, frame_err
  );
endinterface

// File: rtl/mse_serial_slave.sv
// MSE serial slave: oversamples SCLK/SDI/SLE in the clk domain and turns each frame
// into single-cycle register-bus strobes. Read data is shifted back on SDO.
module mse_serial_slave #(
  parameter int SYNC_STAGES = 2,
  parameter int FRAME_BITS  = 25
) (
  input  logic              clk,
  input  logic              rst,
  mse_serial_slave_if.slave io_mse
);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_WDATA, S_RREQ, S_RCAP, S_RSHIFT, S_DONE
  } state_t;

  localparam logic [4:0] C_FRAME    = 5'(FRAME_BITS);
  localparam logic [4:0] C_SAT      = 5'(FRAME_BITS + 1);
  localparam logic [4:0] C_CMD_LAST = 5'd8;
  localparam logic [4:0] C_RD_FIRST = 5'd9;
  localparam logic [4:0] C_SDO_BITS = 5'd16;

  logic [SYNC_STAGES-1:0] r_sclk_sync, r_sdi_sync, r_sle_sync;
  logic                   r_sclk_d, r_sle_d;
  logic                   w_sclk, w_sdi, w_sle;
  logic                   w_sclk_rise, w_sclk_fall, w_sle_rise, w_sle_fall;
  logic                   w_end_frame;

  state_t      r_state;
  logic [4:0]  r_count;
  logic [4:0]  r_sent;
  logic [8:0]  r_cmd;
  logic [15:0] r_wdata_sr;
  logic [15:0] r_rdata_sr;
  logic [15:0] r_data;
  logic [7:0]  r_address;
  logic        r_wr, r_rd, r_frame_err, r_sdo, r_srdy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sclk_sync <= '0;
      r_sdi_sync  <= '0;
      // NOTE: the SLE chain resets high so a frame still in flight when reset releases
      // cannot produce a false sle_rise; only a genuine low-to-high SLE opens a frame.
      r_sle_sync  <= '1;
      r_sclk_d    <= 1'b0;
      r_sle_d     <= 1'b1;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], io_mse.mse_sclk};
      r_sdi_sync  <= {r_sdi_sync[SYNC_STAGES-2:0], io_mse.mse_sdi};
      r_sle_sync  <= {r_sle_sync[SYNC_STAGES-2:0], io_mse.mse_sle};
      r_sclk_d    <= w_sclk;
      r_sle_d     <= w_sle;
    end
  end

  assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
  assign w_sdi       = r_sdi_sync[SYNC_STAGES-1];
  assign w_sle       = r_sle_sync[SYNC_STAGES-1];
  assign w_sclk_rise = w_sclk & ~r_sclk_d;
  assign w_sclk_fall = ~w_sclk & r_sclk_d;
  assign w_sle_rise  = w_sle & ~r_sle_d;
  assign w_sle_fall  = ~w_sle & r_sle_d;

  // RSHIFT ends on the SLE level so a fall landing in RREQ/RCAP is not lost.
  assign w_end_frame = ((r_state == S_CMD || r_state == S_WDATA) && w_sle_fall) ||
                       (r_state == S_RSHIFT && !w_sle);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (r_state == S_IDLE && w_sle_rise) begin
      r_count <= '0;
    end else if (w_sclk_rise && w_sle && r_count < C_SAT) begin
      r_count <= r_count + 5'd1;
    end
  end

  // NOTE: every register below is clocked state, so only non-blocking assignments are used.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_sent      <= '0;
      r_cmd       <= '0;
      r_wdata_sr  <= '0;
      r_rdata_sr  <= '0;
      r_data      <= '0;
      r_address   <= '0;
      r_wr        <= 1'b0;
      r_rd        <= 1'b0;
      r_frame_err <= 1'b0;
      r_sdo       <= 1'b0;
      r_srdy      <= 1'b0;
    end else begin
      r_wr        <= 1'b0;
      r_rd        <= 1'b0;
      r_frame_err <= 1'b0;
      if (w_end_frame) begin
        r_state <= S_DONE;
        r_sdo   <= 1'b0;
        if (r_count != C_FRAME) begin
          r_frame_err <= 1'b1;
        end else if (!r_cmd[8]) begin
          r_wr      <= 1'b1;
          r_address <= r_cmd[7:0];
          r_data    <= r_wdata_sr;
        end
      end else begin
        case (r_state)
          S_IDLE: begin
            r_srdy <= 1'b1;
            r_sdo  <= 1'b0;
            if (w_sle_rise) begin
              r_state <= S_CMD;
              r_srdy  <= 1'b0;
            end
          end
          S_CMD: begin
            if (w_sclk_rise) begin
              r_cmd <= {r_cmd[7:0], w_sdi};
              if (r_count == C_CMD_LAST) begin
                if (r_cmd[7]) begin
                  r_state   <= S_RREQ;
                  r_rd      <= 1'b1;
                  r_address <= {r_cmd[6:0], w_sdi};
                end else begin
                  r_state <= S_WDATA;
                end
              end
            end
          end
          S_WDATA: begin
            if (w_sclk_rise && r_count < C_FRAME) begin
              r_wdata_sr <= {r_wdata_sr[14:0], w_sdi};
            end
          end
          S_RREQ: r_state <= S_RCAP;
          S_RCAP: begin
            r_rdata_sr <= io_mse.rdata;
            r_sdo      <= io_mse.rdata[15];
            r_sent     <= 5'd1;
            r_state    <= S_RSHIFT;
          end
          S_RSHIFT: begin
            // The fall that follows the 9th rise is skipped: bit 15 must survive until rise 10.
            if (w_sclk_fall && r_count > C_RD_FIRST && r_sent < C_SDO_BITS) begin
              r_rdata_sr <= {r_rdata_sr[14:0], 1'b0};
              r_sdo      <= r_rdata_sr[14];
              r_sent     <= r_sent + 5'd1;
            end
          end
          S_DONE: begin
            r_state <= S_IDLE;
            r_srdy  <= 1'b1;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign io_mse.mse_sdo   = r_sdo;
  assign io_mse.mse_srdy  = r_srdy;
  assign io_mse.address   = r_address;
  assign io_mse.data      = r_data;
  assign io_mse.wr        = r_wr;
  assign io_mse.rd        = r_rd;
  assign io_mse.frame_err = r_frame_err;

endmodule

// File: tb/tb_mse_serial_slave.sv
// Self-checking bench for mse_serial_slave: a bit-banging MSE master plus a frame-level
// reference model that predicts strobes, bus values and SDO read-back per frame.
module tb_mse_serial_slave;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mse_serial_slave_if bus ();

  mse_serial_slave #(.SYNC_STAGES(2), .FRAME_BITS(25)) dut (
    .clk    (clk),
    .rst    (rst),
    .io_mse (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Pulse monitor, sampled on the falling edge away from DUT updates.
  int          cyc = 0, n_wr = 0, n_rd = 0, n_fe = 0, wr_cyc = 0, srdy_cyc = 0;
  logic [7:0]  wr_addr, rd_addr;
  logic [15:0] wr_data;
  logic        srdy_prev = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (bus.wr) begin
      n_wr++;
      wr_addr = bus.address;
      wr_data = bus.data;
      wr_cyc  = cyc;
    end
    if (bus.rd) begin
      n_rd++;
      rd_addr = bus.address;
    end
    if (bus.frame_err) n_fe++;
    if (bus.mse_srdy && !srdy_prev) srdy_cyc = cyc;
    srdy_prev = bus.mse_srdy;
  end

  // Register block: valid read data only in the cycle after rd, noise otherwise.
  logic [15:0] rd_value = '0;
  logic        prev_rd  = 1'b0;
  always @(posedge clk) begin
    #1;
    bus.rdata = prev_rd ? rd_value : 16'($urandom);
    prev_rd   = bus.rd;
  end

  logic [7:0]  model_addr = '0;
  logic [15:0] model_data = '0;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic frame_bit(input int k, input logic rw, input logic [7:0] a,
                                     input logic [15:0] d, input logic [1:0] extra);
    if (k == 0)      return rw;
    else if (k < 9)  return a[8-k];
    else if (k < 25) return d[24-k];
    else             return extra[k-25];
  endfunction

  // One SCLK period of 8 clk: SDI set with SCLK low, SDO/SRDY sampled just before the rise.
  task automatic drive_bit(input logic b, output logic so, output logic sr);
    bus.mse_sdi = b;
    tick(4);
    so = bus.mse_sdo;
    sr = bus.mse_srdy;
    bus.mse_sclk = 1'b1;
    tick(4);
    bus.mse_sclk = 1'b0;
  endtask

  task automatic run_frame(input int nbits, input logic rw, input logic [7:0] a,
                           input logic [15:0] d, input logic [15:0] rdv, input int gap);
    int          wr0, rd0, fe0;
    logic [15:0] rx;
    logic        srdy_hi, so, sr, exp_rd, exp_wr, exp_fe;
    logic [1:0]  extra;
    extra    = 2'($urandom);
    rd_value = rdv;
    wr0 = n_wr; rd0 = n_rd; fe0 = n_fe;
    srdy_hi = 1'b0;
    rx = '0;
    bus.mse_sle = 1'b1;
    tick(4);
    for (int k = 0; k < nbits; k++) begin
      drive_bit(frame_bit(k, rw, a, d, extra), so, sr);
      if (sr) srdy_hi = 1'b1;
      if (k >= 9 && k < 25) rx[24-k] = so;
    end
    tick(4);
    bus.mse_sle = 1'b0;
    bus.mse_sdi = 1'b0;
    tick(gap);

    exp_rd = (nbits >= 9) && rw;
    exp_wr = (nbits == 25) && !rw;
    exp_fe = (nbits != 25);
    if (exp_rd) model_addr = a;
    if (exp_wr) begin
      model_addr = a;
      model_data = d;
    end

    check("wr_pulses", n_wr - wr0, 32'(exp_wr));
    check("rd_pulses", n_rd - rd0, 32'(exp_rd));
    check("err_pulses", n_fe - fe0, 32'(exp_fe));
    check("srdy_in_frame", srdy_hi, 0);
    check("srdy_after", bus.mse_srdy, 1);
    check("sdo_idle", bus.mse_sdo, 0);
    check("address", bus.address, model_addr);
    check("data", bus.data, model_data);
    if (exp_wr) begin
      check("wr_addr", wr_addr, a);
      check("wr_data", wr_data, d);
      check("wr_to_srdy", srdy_cyc - wr_cyc, 1);
    end
    if (exp_rd) check("rd_addr", rd_addr, a);
    if (exp_rd && nbits >= 25) check("sdo_word", rx, rdv);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wr"}, bus.wr, 0);
    check({tag, "_rd"}, bus.rd, 0);
    check({tag, "_err"}, bus.frame_err, 0);
    check({tag, "_sdo"}, bus.mse_sdo, 0);
    check({tag, "_srdy"}, bus.mse_srdy, 0);
    check({tag, "_addr"}, bus.address, 0);
    check({tag, "_data"}, bus.data, 0);
  endtask

  initial begin
    logic so, sr;
    int   wr0, fe0, rd0;
    logic [7:0]  ra;
    logic [15:0] rdat;
    bus.mse_sclk = 1'b0;
    bus.mse_sdi  = 1'b0;
    bus.mse_sle  = 1'b0;

    tick(3);
    check_reset_outputs("por");
    rst = 1'b1;
    tick(1);
    check("srdy_release", bus.mse_srdy, 1);
    tick(4);

    run_frame(25, 1'b0, 8'h3C, 16'hA55A, 16'h0000, 6);
    run_frame(25, 1'b1, 8'h81, 16'h0000, 16'h1234, 6);
    run_frame(20, 1'b0, 8'h44, 16'hBEEF, 16'h0000, 6);
    run_frame(27, 1'b0, 8'h55, 16'hC3C3, 16'h0000, 6);
    run_frame(25, 1'b0, 8'h66, 16'h0F0F, 16'h0000, 6);

    // Reset in the middle of a write: nothing from the aborted frame may escape.
    wr0 = n_wr; fe0 = n_fe; rd0 = n_rd;
    bus.mse_sle = 1'b1;
    tick(4);
    for (int k = 0; k < 12; k++) drive_bit(frame_bit(k, 1'b0, 8'h77, 16'h1111, 2'b00), so, sr);
    rst = 1'b0;
    #1;
    check_reset_outputs("midrst");
    model_addr = '0;
    model_data = '0;
    tick(3);
    rst = 1'b1;
    tick(1);
    check("srdy_midrst_release", bus.mse_srdy, 1);
    for (int k = 12; k < 25; k++) drive_bit(frame_bit(k, 1'b0, 8'h77, 16'h1111, 2'b00), so, sr);
    tick(4);
    bus.mse_sle = 1'b0;
    tick(8);
    check("midrst_wr", n_wr - wr0, 0);
    check("midrst_err", n_fe - fe0, 0);
    check("midrst_rd", n_rd - rd0, 0);
    check("midrst_addr", bus.address, 0);
    run_frame(25, 1'b0, 8'h99, 16'h5AA5, 16'h0000, 6);

    // Back-to-back writes at the minimum SLE gap.
    run_frame(25, 1'b0, 8'h01, 16'h0001, 16'h0000, 5);
    run_frame(25, 1'b0, 8'h02, 16'h0002, 16'h0000, 5);

    for (int i = 0; i < 40; i++) begin
      ra   = 8'($urandom);
      rdat = 16'($urandom);
      run_frame(($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 27)) : 25,
                1'($urandom), ra, 16'($urandom), rdat, int'($urandom_range(5, 12)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
